load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the 5-stage RV32 pipeline. Consumes the memory-stage outputs of the execute/memory pipeline register and runs one access at a time on a req/ack data-memory bus. Raises `stall_o` to freeze the front of the pipeline until the access completes. Returns load data for the memory/writeback register.

## Interface
- `DATA_WIDTH`, 32, data and address width.
- `BE_WIDTH`, 4, byte enables, DATA_WIDTH/8.
- `clk  in  1`: the single clock.
- `rst_i  in  1`: reset, synchronous, active-high.
- `alu_result_m_i  in  DATA_WIDTH`: byte address.
- `write_data_m_i  in  DATA_WIDTH`: store data; the byte store uses [7:0].
- `mem_write_m_i  in  1`: 1 = store, 0 = load.
- `byte_op_m_i  in  1`: 1 = byte access, 0 = word access.
- `memory_m_i  in  1`: a valid memory instruction is in M.
- `read_data_m_o  out  DATA_WIDTH`: registered load result.
- `stall_o  out  1`: combinational; hold the pipeline.
- `mem_req_o  out  1`: bus request.
- `mem_we_o  out  1`: bus write.
- `mem_addr_o  out  DATA_WIDTH`: word-aligned address, [1:0] = 0.
- `mem_wdata_o  out  DATA_WIDTH`: write data.
- `mem_be_o  out  BE_WIDTH`: byte enables.
- `mem_rdata_i  in  DATA_WIDTH`: read data, valid on the ack cycle.
- `mem_ack_i  in  1`: access complete; sampled only while `mem_req_o` = 1.

## Operation
- FSM states: IDLE, REQ, DONE, plus DRAIN when the store buffer is compiled in.
- IDLE, `memory_m_i`=1:
  - Latch address, we, data and be into the bus registers.
  - Go to REQ.
  - `stall_o`=1 in this cycle.
- REQ:
  - `mem_req_o`=1; address, data, be and we are held stable.
  - `mem_ack_i`=1 → DONE. A load captures `mem_rdata_i` this cycle.
  - Otherwise stay in REQ.
  - `stall_o`=1.
- DONE:
  - `stall_o`=0 and `mem_req_o`=0.
  - Always → IDLE next cycle; the pipeline advances on that edge.
  - A back-to-back memory instruction then starts from IDLE.
- `memory_m_i`=0 in IDLE: no bus activity, `stall_o`=0.
- Word access: `mem_addr_o` = {addr[31:2], 2'b00}, `mem_be_o`=4'b1111. addr[1:0] is ignored; there is no misalignment trap.
- Byte store:
  - `mem_be_o` = 1 << addr[1:0].
  - `mem_wdata_o` = write_data[7:0] replicated ×4.
- Byte load: `read_data_m_o` = zero-extended lane addr[1:0] of `mem_rdata_i`.
- Word load: `read_data_m_o` = `mem_rdata_i`.
- `read_data_m_o` changes only on a load ack. It holds across stores and idle cycles.

## Timing
- Reset values, registered on the `rst_i` edge: state=IDLE; `read_data_m_o`, `mem_addr_o`, `mem_wdata_o` = 0; `mem_be_o`=0; `mem_we_o`=0; `mem_req_o`=0. The store buffer is emptied.
- `stall_o` is forced to 0 while `rst_i`=1.
- Latency with ack in the first REQ cycle: access in M at cycle 0 → REQ at cycle 1 → DONE at cycle 2. That is 2 stall cycles; each wait cycle adds 1.
- Reset mid-REQ: `mem_req_o` drops on the next edge. The bus must tolerate an abandoned request. A pending buffered store is lost.
- `mem_ack_i` while `mem_req_o`=0 is ignored.

## Configuration
- `STORE_BUFFER_EN` defined: a 1-entry posted store buffer is added.
  - Store in IDLE with buffer empty: captured into the buffer in that cycle with `stall_o`=0 (zero-stall store). The buffer drains in the background through DRAIN. Ack → buffer empty → IDLE.
  - Store while the buffer is occupied: stall until the drain ack, then capture on the following cycle (IDLE).
  - Load while the buffer is occupied: stall until the drain ack, then the normal load sequence. Loads never bypass the buffer; there is no forwarding.
- `STORE_BUFFER_EN` undefined: stores take the IDLE→REQ→DONE path like loads, with 2+ stall cycles.

## Structure
- Package `mem_pkg`:
  - `lsu_state_t` enum (IDLE, REQ, DONE, DRAIN).
  - `BE_WIDTH` and byte-lane constants.
  - Byte-enable and lane-extract functions.
- Sub-module `store_buffer`, instantiated only under `STORE_BUFFER_EN`:
  - Holds valid/addr/data/be.
  - Owns the drain request.

## Test plan
- Word load, addr 0x0000_0104, memory returns 0xDEAD_BEEF with ack on the first REQ cycle → `mem_addr_o`=0x104, be=4'hF, `stall_o` high 2 cycles, `read_data_m_o`=0xDEAD_BEEF at DONE.
- Byte load, addr 0x0000_0103, rdata 0x11223344 → `read_data_m_o`=0x0000_0011.
- Byte store, addr 0x0000_0042, data 0x0000_00A5 → be=4'b0100, wdata=0xA5A5A5A5, `mem_we_o`=1.
- Ack delayed 3 cycles → 5 stall cycles. Request fields stay stable throughout; back-to-back loads issue two separate bus requests.
- Reset asserted in REQ → next cycle `mem_req_o`=0, state IDLE, all outputs at reset values.
- `STORE_BUFFER_EN`: store then an immediate load → store has 0 stall cycles; the load stalls until the drain ack, then runs the normal load sequence.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Byte-lane geometry, FSM state encoding, byte-enable and lane-extract helpers.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int BYTE_LANES = WORD_W / BYTE_W;
    localparam int LANE_W     = $clog2(BYTE_LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } lsu_state_t;

    function automatic logic [BYTE_LANES-1:0] lane_enable(
        input logic              byte_op,
        input logic [LANE_W-1:0] lane
    );
        logic [BYTE_LANES-1:0] be;
        be = '1;
        if (byte_op) begin
            be = {{(BYTE_LANES-1){1'b0}}, 1'b1} << lane;
        end
        return be;
    endfunction

    function automatic logic [WORD_W-1:0] store_data(
        input logic              byte_op,
        input logic [WORD_W-1:0] wdata
    );
        if (byte_op) begin
            return {BYTE_LANES{wdata[BYTE_W-1:0]}};
        end
        return wdata;
    endfunction

    function automatic logic [WORD_W-1:0] lane_extract(
        input logic              byte_op,
        input logic [LANE_W-1:0] lane,
        input logic [WORD_W-1:0] rdata
    );
        logic [WORD_W-1:0] shifted;
        shifted = rdata >> {lane, 3'b000};
        if (byte_op) begin
            return {{(WORD_W-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
        end
        return rdata;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// One-entry posted store buffer; drains in the background on the data bus.
// Present only when STORE_BUFFER_EN is defined.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  i_capture,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_WIDTH-1:0]   i_be,
    input  logic                  i_ack,
    output logic                  o_req,
    output logic [DATA_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [BE_WIDTH-1:0]   o_be
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;

    // The drain request is simply the valid bit: a full buffer always drains.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_be    <= i_be;
        end else if (r_valid && i_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign o_req   = r_valid;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_be    = r_be;

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/ack bus access at a time, stalls M.
// Define STORE_BUFFER_EN to add a one-entry posted store buffer.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] alu_result_m_i,
    input  logic [DATA_WIDTH-1:0] write_data_m_i,
    input  logic                  mem_write_m_i,
    input  logic                  byte_op_m_i,
    input  logic                  memory_m_i,
    output logic [DATA_WIDTH-1:0] read_data_m_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    lsu_state_t            r_state;
    logic                  r_req;
    logic                  r_we;
    logic                  r_byte_op;
    logic [LANE_W-1:0]     r_lane;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [BE_WIDTH-1:0]   r_be;

    logic                  w_idle;
    logic                  w_start;
    logic [LANE_W-1:0]     w_lane;
    logic [DATA_WIDTH-1:0] w_addr_aligned;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_WIDTH-1:0]   w_be;

    assign w_idle         = (r_state == IDLE);
    assign w_lane         = alu_result_m_i[LANE_W-1:0];
    assign w_addr_aligned = {alu_result_m_i[DATA_WIDTH-1:LANE_W],
                             {LANE_W{1'b0}}};
    assign w_wdata        = store_data(byte_op_m_i, write_data_m_i);
    assign w_be           = lane_enable(byte_op_m_i, w_lane);

`ifdef STORE_BUFFER_EN
    logic                  w_drain;
    logic                  w_sb_capture;
    logic                  w_sb_req;
    logic                  w_sb_ack;
    logic [DATA_WIDTH-1:0] w_sb_addr;
    logic [DATA_WIDTH-1:0] w_sb_wdata;
    logic [BE_WIDTH-1:0]   w_sb_be;

    // The buffer is always empty in IDLE, so an IDLE store posts at once.
    assign w_drain      = (r_state == DRAIN);
    assign w_sb_capture = w_idle && memory_m_i && mem_write_m_i;
    assign w_start      = w_idle && memory_m_i && !mem_write_m_i;
    assign w_sb_ack     = w_sb_req && mem_ack_i;

    assign stall_o = !rst_i &&
                     (w_start || (r_state == REQ) ||
                      (w_drain && memory_m_i));

    store_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_store_buffer (
        .clk       (clk),
        .rst_i     (rst_i),
        .i_capture (w_sb_capture),
        .i_addr    (w_addr_aligned),
        .i_wdata   (w_wdata),
        .i_be      (w_be),
        .i_ack     (w_sb_ack),
        .o_req     (w_sb_req),
        .o_addr    (w_sb_addr),
        .o_wdata   (w_sb_wdata),
        .o_be      (w_sb_be)
    );

    assign mem_req_o   = w_drain ? w_sb_req   : r_req;
    assign mem_we_o    = w_drain ? 1'b1       : r_we;
    assign mem_addr_o  = w_drain ? w_sb_addr  : r_addr;
    assign mem_wdata_o = w_drain ? w_sb_wdata : r_wdata;
    assign mem_be_o    = w_drain ? w_sb_be    : r_be;
`else
    assign w_start = w_idle && memory_m_i;

    assign stall_o = !rst_i && (w_start || (r_state == REQ));

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_byte_op <= 1'b0;
            r_lane    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_be      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= REQ;
                        r_req     <= 1'b1;
                        r_we      <= mem_write_m_i;
                        r_byte_op <= byte_op_m_i;
                        r_lane    <= w_lane;
                        r_addr    <= w_addr_aligned;
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                    end
`ifdef STORE_BUFFER_EN
                    else if (w_sb_capture) begin
                        r_state <= DRAIN;
                    end
`endif
                end
                REQ: begin
                    // Ack is only honoured here, so a stray ack elsewhere is ignored.
                    if (mem_ack_i) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= lane_extract(r_byte_op, r_lane,
                                                    mem_rdata_i);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
`ifdef STORE_BUFFER_EN
                DRAIN: begin
                    if (w_sb_ack) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign read_data_m_o = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural bus/load model.
// Directed spec cases plus randomized accesses with random ack latency.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] alu_result_m_i;
    logic [31:0] write_data_m_i;
    logic        mem_write_m_i;
    logic        byte_op_m_i;
    logic        memory_m_i;
    logic [31:0] read_data_m_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .alu_result_m_i (alu_result_m_i),
        .write_data_m_i (write_data_m_i),
        .mem_write_m_i  (mem_write_m_i),
        .byte_op_m_i    (byte_op_m_i),
        .memory_m_i     (memory_m_i),
        .read_data_m_o  (read_data_m_o),
        .stall_o        (stall_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ack_i      (mem_ack_i)
    );

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [3:0] exp_be(input logic bop,
                                          input logic [31:0] a);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) begin
            be[i] = !bop || (i == int'(a[1:0]));
        end
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic bop,
                                              input logic [31:0] d);
        return bop ? 32'h0101_0101 * {24'h0, d[7:0]} : d;
    endfunction

    function automatic logic [31:0] exp_load(input logic bop,
                                             input logic [31:0] a,
                                             input logic [31:0] rd);
        return bop ? (rd >> (8 * a[1:0])) & 32'hFF : rd;
    endfunction

    // Issue one access from IDLE and act as a memory acking after 'delay' waits.
    task automatic run_access(input string name, input logic we,
                              input logic bop, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int delay);
        int stalls;
        int reqs;
        bit done;
        @(negedge clk);
        memory_m_i     = 1'b1;
        mem_write_m_i  = we;
        byte_op_m_i    = bop;
        alu_result_m_i = a;
        write_data_m_i = wd;
        mem_ack_i      = 1'b0;
        stalls = 0;
        reqs   = 0;
        done   = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (!stall_o) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_req_o) begin
                    reqs++;
                    checks++;
                    if (mem_addr_o !== exp_addr(a) ||
                        mem_be_o !== exp_be(bop, a) ||
                        mem_we_o !== we ||
                        (we && mem_wdata_o !== exp_wdata(bop, wd))) begin
                        errors++;
                        $display("FAIL %s bus: addr=%h be=%b we=%b wd=%h want addr=%h be=%b we=%b wd=%h",
                                 name, mem_addr_o, mem_be_o, mem_we_o,
                                 mem_wdata_o, exp_addr(a), exp_be(bop, a),
                                 we, exp_wdata(bop, wd));
                    end
                    mem_ack_i   = (reqs == delay + 1);
                    mem_rdata_i = mem_ack_i ? rd : $urandom;
                end else begin
                    mem_ack_i = 1'b0;
                end
                @(negedge clk);
            end
        end
        mem_ack_i = 1'b0;
        if (!we) model_rd = exp_load(bop, a, rd);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: stall_o never dropped", name);
        end
        checks++;
        if (stalls != delay + 2) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d want %0d",
                     name, stalls, delay + 2);
        end
        checks++;
        if (reqs != delay + 1) begin
            errors++;
            $display("FAIL %s req cycles: got %0d want %0d",
                     name, reqs, delay + 1);
        end
        checks++;
        if (mem_req_o !== 1'b0 || read_data_m_o !== model_rd) begin
            errors++;
            $display("FAIL %s done: req=%b rdata=%h want req=0 rdata=%h",
                     name, mem_req_o, read_data_m_o, model_rd);
        end
    endtask

    task automatic test_reset();
        rst_i          = 1'b1;
        memory_m_i     = 1'b1;
        mem_write_m_i  = 1'b0;
        byte_op_m_i    = 1'b0;
        alu_result_m_i = 32'h100;
        write_data_m_i = 32'h0;
        mem_rdata_i    = 32'h0;
        mem_ack_i      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 ||
            mem_be_o !== 4'h0 || read_data_m_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: stall=%b req=%b we=%b addr=%h wd=%h be=%b rd=%h want all 0",
                     stall_o, mem_req_o, mem_we_o, mem_addr_o,
                     mem_wdata_o, mem_be_o, read_data_m_o);
        end
        @(negedge clk);
        rst_i      = 1'b0;
        memory_m_i = 1'b0;
        model_rd   = 32'h0;
    endtask

    task automatic test_word_load();
        run_access("word_load", 1'b0, 1'b0, 32'h0000_0104, 32'h0,
                   32'hDEAD_BEEF, 0);
        checks++;
        if (read_data_m_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_load value: got %h want deadbeef",
                     read_data_m_o);
        end
    endtask

    task automatic test_byte_load();
        run_access("byte_load", 1'b0, 1'b1, 32'h0000_0103, 32'h0,
                   32'h1122_3344, 0);
        checks++;
        if (read_data_m_o !== 32'h0000_0011) begin
            errors++;
            $display("FAIL byte_load value: got %h want 00000011",
                     read_data_m_o);
        end
    endtask

    task automatic test_byte_store();
        run_access("byte_store", 1'b1, 1'b1, 32'h0000_0042, 32'h0000_00A5,
                   32'h0, 0);
        checks++;
        if (mem_be_o !== 4'b0100 || mem_wdata_o !== 32'hA5A5_A5A5 ||
            mem_we_o !== 1'b1) begin
            errors++;
            $display("FAIL byte_store fields: be=%b wd=%h we=%b want 0100 a5a5a5a5 1",
                     mem_be_o, mem_wdata_o, mem_we_o);
        end
    endtask

    task automatic test_wait_states();
        run_access("wait_load", 1'b0, 1'b0, 32'h0000_2A6B, 32'h0,
                   32'hCAFE_F00D, 3);
`ifndef STORE_BUFFER_EN
        run_access("wait_store", 1'b1, 1'b0, 32'h0000_3001, 32'h1357_9BDF,
                   32'h0, 3);
`endif
    endtask

    task automatic test_back_to_back();
        run_access("b2b_first", 1'b0, 1'b1, 32'h0000_0201, 32'h0,
                   32'hA1B2_C3D4, 1);
        run_access("b2b_second", 1'b0, 1'b0, 32'h0000_0300, 32'h0,
                   32'h0BAD_F00D, 0);
    endtask

    task automatic test_idle_ack();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            memory_m_i  = 1'b0;
            mem_ack_i   = 1'b1;
            mem_rdata_i = $urandom;
            #1;
            checks++;
            if (stall_o !== 1'b0 || mem_req_o !== 1'b0 ||
                read_data_m_o !== model_rd) begin
                errors++;
                $display("FAIL idle_ack: stall=%b req=%b rd=%h want 0 0 %h",
                         stall_o, mem_req_o, read_data_m_o, model_rd);
            end
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        memory_m_i     = 1'b1;
        mem_write_m_i  = 1'b0;
        byte_op_m_i    = 1'b0;
        alu_result_m_i = 32'h0000_0808;
        mem_ack_i      = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_req setup: req=%b want 1", mem_req_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_req stall in reset: got %b want 0", stall_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 ||
            mem_be_o !== 4'h0 || read_data_m_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_req reset: req=%b we=%b addr=%h wd=%h be=%b rd=%h want all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                     mem_be_o, read_data_m_o);
        end
        rst_i      = 1'b0;
        memory_m_i = 1'b0;
        model_rd   = 32'h0;
        run_access("after_reset", 1'b0, 1'b0, 32'h0000_0010, 32'h0,
                   32'h7777_1234, 0);
    endtask

    task automatic test_random();
        logic        we;
        logic        bop;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
`ifdef STORE_BUFFER_EN
            we = 1'b0;
`else
            we = 1'($urandom_range(0, 1));
`endif
            bop = 1'($urandom_range(0, 1));
            a   = $urandom;
            run_access("random", we, bop, a, $urandom, $urandom,
                       int'($urandom_range(0, 4)));
        end
    endtask

`ifdef STORE_BUFFER_EN
    task automatic test_store_buffer();
        int          stalls;
        int          drains;
        int          loads;
        bit          done;
        logic [31:0] rdv;
        rdv = $urandom;
        @(negedge clk);
        memory_m_i     = 1'b1;
        mem_write_m_i  = 1'b1;
        byte_op_m_i    = 1'b1;
        alu_result_m_i = 32'h0000_0042;
        write_data_m_i = 32'h0000_00A5;
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_store stall: stall=%b req=%b want 0 0",
                     stall_o, mem_req_o);
        end
        @(negedge clk);
        mem_write_m_i  = 1'b0;
        byte_op_m_i    = 1'b0;
        alu_result_m_i = 32'h0000_0104;
        stalls = 0;
        drains = 0;
        loads  = 0;
        done   = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (!stall_o) begin
                done = 1;
            end else begin
                stalls++;
                mem_ack_i = 1'b0;
                if (mem_req_o && mem_we_o) begin
                    drains++;
                    checks++;
                    if (mem_addr_o !== 32'h40 || mem_be_o !== 4'b0100 ||
                        mem_wdata_o !== 32'hA5A5_A5A5) begin
                        errors++;
                        $display("FAIL sb_drain bus: addr=%h be=%b wd=%h want 40 0100 a5a5a5a5",
                                 mem_addr_o, mem_be_o, mem_wdata_o);
                    end
                    mem_ack_i = (drains == 3);
                end else if (mem_req_o) begin
                    loads++;
                    checks++;
                    if (mem_addr_o !== 32'h104 || mem_be_o !== 4'hF ||
                        drains != 3) begin
                        errors++;
                        $display("FAIL sb_load bus: addr=%h be=%b drains=%0d want 104 1111 3",
                                 mem_addr_o, mem_be_o, drains);
                    end
                    mem_ack_i = 1'b1;
                end
                mem_rdata_i = mem_ack_i ? rdv : $urandom;
                @(negedge clk);
            end
        end
        mem_ack_i  = 1'b0;
        memory_m_i = 1'b0;
        model_rd   = rdv;
        checks++;
        if (!done || stalls != 5 || drains != 3 || loads != 1 ||
            read_data_m_o !== rdv) begin
            errors++;
            $display("FAIL sb_sequence: done=%0d stalls=%0d drains=%0d loads=%0d rd=%h want 1 5 3 1 %h",
                     done, stalls, drains, loads, read_data_m_o, rdv);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
`ifdef STORE_BUFFER_EN
        test_store_buffer();
`else
        test_byte_store();
`endif
        test_wait_states();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid_req();
        test_random();
        test_idle_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
